// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's single write port between two writeback sources:
//   A - single-cycle ALU result path. It has fixed priority.
//   B - multi-cycle load/mul unit. A starvation counter forces one B grant
//       after MAX_WAIT stalled cycles.
// A winning transfer is registered onto the write port one cycle later.
//
// Ports
//   clk, rst_n              rising-edge clock, async active-low reset
//   a_valid/a_ready         A handshake (ready is combinational)
//   a_addr/a_data           A destination register and write data
//   b_valid/b_ready         B handshake (ready is combinational)
//   b_addr/b_data           B destination register and write data
//   rf_we/rf_waddr/rf_wdata registered register-file write port
//   b_forced                registered 1-cycle pulse: the last write was a
//                           starvation-forced B grant
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4    // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              b_forced
);

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_B = 1'b1
  } state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_t     state, state_next;
  logic [3:0] wait_cnt, wait_next;
  logic       a_xfer, b_xfer, b_stall;

  assign a_xfer  = a_valid && a_ready;
  assign b_xfer  = b_valid && b_ready;
  assign b_stall = b_valid && !b_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the edge, whatever the order of
  // the statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block. A path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;

    // The counter counts stalled B cycles and saturates at 15.
    if (b_xfer) begin
      wait_next = '0;
    end else if (b_stall && (wait_cnt != 4'hF)) begin
      wait_next = wait_cnt + 4'd1;
    end

    unique case (state)
      NORMAL: begin
        // The forced grant is taken in the cycle after the limit is reached.
        if (b_stall && (wait_next >= WAIT_LIMIT)) begin
          state_next = FORCE_B;
        end
      end
      FORCE_B: begin
        // The state leaves on the forced transfer. It also leaves if B
        // withdrew its request, and then nothing is written.
        state_next = NORMAL;
        wait_next  = '0;
      end
      default: state_next = NORMAL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output (ready) logic
  // ---------------------------------------------------------------------------
  always_comb begin
    a_ready = 1'b1;
    b_ready = !a_valid;
    if (state == FORCE_B) begin
      a_ready = 1'b0;
      b_ready = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port. Register 0 still loads addr/data but never writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      b_forced <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      b_forced <= 1'b0;
      if (a_xfer) begin
        rf_we    <= (a_addr != '0);
        rf_waddr <= a_addr;
        rf_wdata <= a_data;
      end else if (b_xfer) begin
        rf_we    <= (b_addr != '0);
        rf_waddr <= b_addr;
        rf_wdata <= b_data;
        b_forced <= (state == FORCE_B);
      end
    end
  end

endmodule
